ttc_count_rst_multi: RTL

TTC_COUNT_RST_MULTI -- requirements
Module: ttc_count_rst_multi

---
 rtl/ttc_count_rst_multi.sv | 90 +++++++++
 1 files changed

// File: rtl/ttc_count_rst_multi.sv
// Multi-channel timer clock-control block: per-channel control register,
// prescaler counter and registered count enable with edge-detected restart.

module ttc_count_rst_ch #(
    parameter int CTRL_W = 7,
    parameter int PS_W   = 16
) (
    input  logic              pclk,
    input  logic              n_p_reset,
    input  logic [CTRL_W-1:0] pwdata,
    input  logic              sel,
    input  logic              restart,
    output logic              count_en,
    output logic [CTRL_W-1:0] clk_ctrl_reg,
    output logic [PS_W-1:0]   ps_cnt
);
    logic            restart_var;
    logic            restart_edge;
    logic [PS_W-1:0] term_cnt;
    int              exp_n;

    assign restart_edge = restart & ~restart_var;

    // Terminal count D-1 is a mask of min(P+1, PS_W) ones.
    always_comb begin
        exp_n    = int'({28'd0, clk_ctrl_reg[4:1]}) + 1;
        term_cnt = '0;
        for (int b = 0; b < PS_W; b++) begin
            if (b < exp_n) term_cnt[b] = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            clk_ctrl_reg <= '0;
            restart_var  <= 1'b0;
            ps_cnt       <= '0;
            count_en     <= 1'b0;
        end else begin
            // Tracks the restart level, so a held restart yields one edge.
            restart_var <= restart;
            if (sel) clk_ctrl_reg <= pwdata;

            if (restart_edge || sel) begin
                ps_cnt   <= '0;
                count_en <= 1'b0;
            end else if (!clk_ctrl_reg[0]) begin
                ps_cnt   <= '0;
                count_en <= 1'b1;
            end else if (ps_cnt == term_cnt) begin
                ps_cnt   <= '0;
                count_en <= 1'b1;
            end else begin
                ps_cnt   <= ps_cnt + 1'b1;
                count_en <= 1'b0;
            end
        end
    end
endmodule

module ttc_count_rst_multi #(
    parameter int NUM_CH = 3,
    parameter int CTRL_W = 7,
    parameter int PS_W   = 16
) (
    input  logic                     n_p_reset,
    input  logic                     pclk,
    input  logic [CTRL_W-1:0]        pwdata,
    input  logic [NUM_CH-1:0]        clk_ctrl_reg_sel,
    input  logic [NUM_CH-1:0]        restart,
    output logic [NUM_CH-1:0]        count_en_out,
    output logic [NUM_CH*CTRL_W-1:0] clk_ctrl_reg_out,
    output logic [NUM_CH*PS_W-1:0]   ps_cnt_out
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ttc_count_rst_ch #(
            .CTRL_W (CTRL_W),
            .PS_W   (PS_W)
        ) u_ch (
            .pclk         (pclk),
            .n_p_reset    (n_p_reset),
            .pwdata       (pwdata),
            .sel          (clk_ctrl_reg_sel[i]),
            .restart      (restart[i]),
            .count_en     (count_en_out[i]),
            .clk_ctrl_reg (clk_ctrl_reg_out[i*CTRL_W +: CTRL_W]),
            .ps_cnt       (ps_cnt_out[i*PS_W +: PS_W])
        );
    end
endmodule
